// File: rtl/rv_instr_encoder.sv
// -----------------------------------------------------------------------------
// rv_instr_encoder
//
// Streaming RV32 instruction encoder. Takes decoded instruction fields over a
// valid/ready handshake and emits one packed 32-bit instruction word per
// accepted input. Each word carries a sequential instruction-memory word index.
// Supported classes: R, I-ALU, LOAD, STORE, BRANCH and the custom CTZ.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of output word, address, count, err, full
//   in_valid/in_ready input handshake (in_ready is combinational on out_ready)
//   in_class          0=R 1=I-ALU 2=LOAD 3=STORE 4=BRANCH 5=CTZ 6/7=illegal
//   in_rd/rs1/rs2     register fields
//   in_funct3/funct7  function fields
//   in_imm            13-bit signed immediate
//   out_valid/ready   output handshake
//   out_instr         encoded word
//   out_addr          word index of out_instr
//   count             words handed off since reset/flush
//   full              last word index handed off; intake stopped
//   err               sticky: an illegal class or misaligned branch was dropped
// -----------------------------------------------------------------------------
module rv_instr_encoder #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_class,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [12:0]           in_imm,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_instr,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  err
);

   localparam logic [2:0] CLS_R      = 3'd0;
   localparam logic [2:0] CLS_I      = 3'd1;
   localparam logic [2:0] CLS_LOAD   = 3'd2;
   localparam logic [2:0] CLS_STORE  = 3'd3;
   localparam logic [2:0] CLS_BRANCH = 3'd4;
   localparam logic [2:0] CLS_CTZ    = 3'd5;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_CTZ    = 7'b1110011;

   // Packs the fields of one instruction; illegal classes produce zero.
   function automatic logic [31:0] encode_instr(
      input logic [2:0]  cls,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [2:0]  f3,
      input logic [6:0]  f7,
      input logic [12:0] imm
   );
      logic [31:0] w;
      w = 32'h0000_0000;
      case (cls)
         CLS_R:      w = {f7, rs2, rs1, f3, rd, OPC_R};
         CLS_I:      w = {imm[11:0], rs1, f3, rd, OPC_I};
         CLS_LOAD:   w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
         CLS_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
         CLS_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
         CLS_CTZ:    w = {f7, 5'b00000, rs1, f3, rd, OPC_CTZ};
         default:    w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   logic                  out_valid_q, out_valid_d;
   logic [31:0]           out_instr_q, out_instr_d;
   logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   logic [ADDR_WIDTH:0]   count_q,     count_d;
   logic                  full_q,      full_d;
   logic                  err_q,       err_d;

   logic                  in_hs_s;
   logic                  out_hs_s;
   logic                  legal_s;
   logic [31:0]           enc_s;

   // Intake allowed while not full and the output slot is free or draining.
   assign in_ready = !full_q && (!out_valid_q || out_ready);

   // Next-state logic: flush overrides everything; an output handshake frees
   // the slot and advances the index before a same-cycle input reloads it, so
   // back-to-back words get consecutive addresses without a bubble.
   always_comb begin
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;
      addr_d      = addr_q;
      count_d     = count_q;
      full_d      = full_q;
      err_d       = err_q;

      in_hs_s  = in_valid && in_ready;
      out_hs_s = out_valid_q && out_ready;
      // Branch offsets are in half-words, so imm[0] must be clear.
      legal_s  = (in_class <= CLS_CTZ) && !((in_class == CLS_BRANCH) && in_imm[0]);
      enc_s    = encode_instr(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

      if (flush) begin
         out_valid_d = 1'b0;
         out_instr_d = 32'h0000_0000;
         out_addr_d  = {ADDR_WIDTH{1'b0}};
         addr_d      = {ADDR_WIDTH{1'b0}};
         count_d     = {(ADDR_WIDTH+1){1'b0}};
         full_d      = 1'b0;
         err_d       = 1'b0;
      end else begin
         if (out_hs_s) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            count_d     = count_q + (ADDR_WIDTH+1)'(1);
            // Handing off the top index exhausts the memory; the index wraps.
            if (out_addr_q == {ADDR_WIDTH{1'b1}}) begin
               full_d = 1'b1;
            end else begin
               full_d = full_q;
            end
         end else begin
            addr_d  = addr_q;
            count_d = count_q;
         end

         if (in_hs_s) begin
            if (legal_s) begin
               out_valid_d = 1'b1;
               out_instr_d = enc_s;
               out_addr_d  = addr_d;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            err_d = err_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0000_0000;
         out_addr_q  <= {ADDR_WIDTH{1'b0}};
         addr_q      <= {ADDR_WIDTH{1'b0}};
         count_q     <= {(ADDR_WIDTH+1){1'b0}};
         full_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = out_addr_q;
   assign count     = count_q;
   assign full      = full_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_rv_instr_encoder
//
// Table of encoded instruction vectors plus directed sequences for
// backpressure, dropped inputs, full/flush and asynchronous reset. A queue
// scoreboard holds {word, address} for every accepted legal input and is
// compared whenever an output handshake occurs.
// -----------------------------------------------------------------------------
module tb_rv_instr_encoder;

   localparam int AW = 2;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_class;
   logic [4:0]    in_rd;
   logic [4:0]    in_rs1;
   logic [4:0]    in_rs2;
   logic [2:0]    in_funct3;
   logic [6:0]    in_funct7;
   logic [12:0]   in_imm;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic [AW:0]   count;
   logic          full;
   logic          err;

   rv_instr_encoder #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_class  (in_class),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .count     (count),
      .full      (full),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [12:0] imm;
      logic        legal;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0]   instr;
      logic [AW-1:0] addr;
   } sb_t;

   vec_t        tbl [0:10];
   sb_t         sb_q [$];
   logic [AW-1:0] m_idx;
   logic        cur_legal;
   logic [31:0] cur_exp;
   int          n_total;
   int          n_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      in_valid  = 1'b1;
      in_class  = v.cls;
      in_rd     = v.rd;
      in_rs1    = v.rs1;
      in_rs2    = v.rs2;
      in_funct3 = v.f3;
      in_funct7 = v.f7;
      in_imm    = v.imm;
      cur_legal = v.legal;
      cur_exp   = v.exp;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      cur_legal = 1'b0;
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_instr"}, out_instr,      32'd0);
      chk({tag, "_out_addr"},  32'(out_addr),  32'd0);
      chk({tag, "_count"},     32'(count),     32'd0);
      chk({tag, "_full"},      32'(full),      32'd0);
      chk({tag, "_err"},       32'(err),       32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
   endtask

   // Scoreboard: sampled on the falling edge, i.e. for the coming rising edge.
   always @(negedge clk) begin
      sb_t e;
      if (!rst_n || flush) begin
         sb_q.delete();
         m_idx = '0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL sb_underflow: got unexpected word 0x%08h at addr %0d", out_instr, out_addr);
            end else begin
               e = sb_q.pop_front();
               chk("sb_instr", out_instr, e.instr);
               chk("sb_addr", 32'(out_addr), 32'(e.addr));
            end
            m_idx = m_idx + AW'(1);
         end
         if (in_valid && in_ready && cur_legal) begin
            e.instr = cur_exp;
            e.addr  = m_idx;
            sb_q.push_back(e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      //          cls    rd     rs1    rs2    f3    f7     imm       legal exp
      tbl[0]  = '{3'd0, 5'd3,  5'd1,  5'd2,  3'd0, 7'd0,  13'h0000, 1'b1, 32'h002081B3}; // ADD x3,x1,x2
      tbl[1]  = '{3'd1, 5'd5,  5'd0,  5'd7,  3'd0, 7'h55, 13'h1FFF, 1'b1, 32'hFFF00293}; // ADDI x5,x0,-1
      tbl[2]  = '{3'd3, 5'd9,  5'd1,  5'd2,  3'd2, 7'h7F, 13'h0008, 1'b1, 32'h0020A423}; // SW x2,8(x1)
      tbl[3]  = '{3'd4, 5'd0,  5'd1,  5'd2,  3'd0, 7'd0,  13'h1FFC, 1'b1, 32'hFE208EE3}; // BEQ x1,x2,-4
      tbl[4]  = '{3'd2, 5'd6,  5'd7,  5'd0,  3'd2, 7'd0,  13'h1800, 1'b1, 32'h8003A303}; // LW x6,-2048(x7)
      tbl[5]  = '{3'd5, 5'd10, 5'd11, 5'd31, 3'd1, 7'h30, 13'h0000, 1'b1, 32'h60059573}; // CTZ
      tbl[6]  = '{3'd0, 5'd31, 5'd30, 5'd29, 3'd0, 7'h20, 13'h0000, 1'b1, 32'h41DF0FB3}; // SUB x31,x30,x29
      tbl[7]  = '{3'd4, 5'd0,  5'd3,  5'd4,  3'd1, 7'd0,  13'h0FFE, 1'b1, 32'h7E419FE3}; // BNE x3,x4,+4094
      tbl[8]  = '{3'd7, 5'd1,  5'd1,  5'd1,  3'd0, 7'd0,  13'h0000, 1'b0, 32'h00000000}; // illegal class 7
      tbl[9]  = '{3'd4, 5'd0,  5'd1,  5'd2,  3'd0, 7'd0,  13'h0003, 1'b0, 32'h00000000}; // misaligned branch
      tbl[10] = '{3'd6, 5'd2,  5'd2,  5'd2,  3'd0, 7'd0,  13'h0000, 1'b0, 32'h00000000}; // illegal class 6

      n_total   = 0;
      n_pass    = 0;
      m_idx     = '0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_class  = 3'd0;
      in_rd     = 5'd0;
      in_rs1    = 5'd0;
      in_rs2    = 5'd0;
      in_funct3 = 3'd0;
      in_funct7 = 7'd0;
      in_imm    = 13'd0;
      cur_exp   = 32'd0;
      idle();

      #12;
      chk_reset_vals("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---- table: each class, one cycle latency, addresses wrap every 4 ----
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i]);
         #1;
         chk("tbl_in_ready", 32'(in_ready), 32'd1);
         tick();
         chk("tbl_out_valid", 32'(out_valid), 32'd1);
         chk("tbl_out_instr", out_instr, tbl[i].exp);
         chk("tbl_out_addr", 32'(out_addr), 32'(i % 4));
         idle();
         tick();
         chk("tbl_drained", 32'(out_valid), 32'd0);
         if ((i % 4) == 3) begin
            chk("tbl_full", 32'(full), 32'd1);
            chk("tbl_count4", 32'(count), 32'd4);
            chk("tbl_full_stall", 32'(in_ready), 32'd0);
            flush_pulse();
            chk("tbl_flush_full", 32'(full), 32'd0);
            chk("tbl_flush_count", 32'(count), 32'd0);
         end
      end

      // ---- backpressure: 5 stalled cycles then release ----
      out_ready = 1'b0;
      drive(tbl[0]);
      tick();
      chk("bp_first_valid", 32'(out_valid), 32'd1);
      drive(tbl[1]);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_hold_instr", out_instr, tbl[0].exp);
         chk("bp_hold_addr", 32'(out_addr), 32'd0);
         chk("bp_hold_count", 32'(count), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      tick();
      chk("bp_w1_instr", out_instr, tbl[1].exp);
      chk("bp_w1_addr", 32'(out_addr), 32'd1);
      chk("bp_w1_count", 32'(count), 32'd1);
      drive(tbl[2]);
      tick();
      chk("bp_w2_instr", out_instr, tbl[2].exp);
      chk("bp_w2_addr", 32'(out_addr), 32'd2);
      chk("bp_w2_count", 32'(count), 32'd2);
      idle();
      tick();
      chk("bp_done_valid", 32'(out_valid), 32'd0);
      chk("bp_done_count", 32'(count), 32'd3);
      flush_pulse();

      // ---- dropped inputs ----
      drive(tbl[0]);
      tick();
      idle();
      tick();
      chk("drop_err_clear", 32'(err), 32'd0);
      drive(tbl[9]);
      #1;
      chk("drop_br_ready", 32'(in_ready), 32'd1);
      tick();
      chk("drop_br_err", 32'(err), 32'd1);
      chk("drop_br_valid", 32'(out_valid), 32'd0);
      chk("drop_br_count", 32'(count), 32'd1);
      drive(tbl[8]);
      tick();
      chk("drop_c7_valid", 32'(out_valid), 32'd0);
      chk("drop_c7_err", 32'(err), 32'd1);
      drive(tbl[1]);
      tick();
      chk("drop_next_valid", 32'(out_valid), 32'd1);
      chk("drop_next_addr", 32'(out_addr), 32'd1);
      chk("drop_next_instr", out_instr, tbl[1].exp);
      idle();
      tick();
      chk("drop_next_count", 32'(count), 32'd2);
      flush_pulse();
      chk("drop_flush_err", 32'(err), 32'd0);
      drive(tbl[10]);
      tick();
      chk("drop_c6_err", 32'(err), 32'd1);
      chk("drop_c6_valid", 32'(out_valid), 32'd0);
      idle();
      flush_pulse();

      // ---- full with back-to-back stream, then flush releases 5th word ----
      for (int i = 0; i < 4; i++) begin
         drive(tbl[i]);
         tick();
         chk("full_stream_valid", 32'(out_valid), 32'd1);
         chk("full_stream_addr", 32'(out_addr), 32'(i));
      end
      idle();
      tick();
      chk("full_set", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd4);
      chk("full_no_valid", 32'(out_valid), 32'd0);
      drive(tbl[4]);
      #1;
      chk("full_stall_ready", 32'(in_ready), 32'd0);
      tick();
      chk("full_stall_valid", 32'(out_valid), 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("full_flush_full", 32'(full), 32'd0);
      chk("full_flush_count", 32'(count), 32'd0);
      #1;
      chk("full_flush_ready", 32'(in_ready), 32'd1);
      tick();
      chk("full_w5_valid", 32'(out_valid), 32'd1);
      chk("full_w5_addr", 32'(out_addr), 32'd0);
      chk("full_w5_instr", out_instr, tbl[4].exp);
      idle();
      tick();
      chk("full_w5_count", 32'(count), 32'd1);
      flush_pulse();

      // ---- flush coincident with a pending output handshake ----
      out_ready = 1'b0;
      drive(tbl[5]);
      tick();
      idle();
      chk("fl_pending_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_valid_cleared", 32'(out_valid), 32'd0);
      chk("fl_not_counted", 32'(count), 32'd0);

      // ---- asynchronous reset mid-stream ----
      drive(tbl[0]);
      tick();
      drive(tbl[1]);
      tick();
      drive(tbl[8]);
      tick();
      out_ready = 1'b0;
      drive(tbl[2]);
      tick();
      idle();
      chk("ar_pre_valid", 32'(out_valid), 32'd1);
      chk("ar_pre_err", 32'(err), 32'd1);
      chk("ar_pre_count", 32'(count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("ar");
      #3;
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      drive(tbl[3]);
      tick();
      chk("ar_next_valid", 32'(out_valid), 32'd1);
      chk("ar_next_addr", 32'(out_addr), 32'd0);
      chk("ar_next_instr", out_instr, tbl[3].exp);
      idle();
      tick();
      chk("ar_next_count", 32'(count), 32'd1);
      tick();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
